// File: rtl/spongent_pkg.sv
// ---------------------------------------------------------------------------
// spongent_pkg
// Shared definitions for the SPONGENT host-side sequencer:
//   - one-hot state encodings and the FSM state type
//   - PAD_BYTE, the first byte of sponge padding
//   - clog2, a constant function used to size ports and counters
// ---------------------------------------------------------------------------
package spongent_pkg;

  localparam logic [7:0] ST_IDLE   = 8'b0000_0001;
  localparam logic [7:0] ST_CLR    = 8'b0000_0010;
  localparam logic [7:0] ST_SETTLE = 8'b0000_0100;
  localparam logic [7:0] ST_MSG    = 8'b0000_1000;
  localparam logic [7:0] ST_CMD    = 8'b0001_0000;
  localparam logic [7:0] ST_WAIT   = 8'b0010_0000;
  localparam logic [7:0] ST_PAD    = 8'b0100_0000;
  localparam logic [7:0] ST_OUT    = 8'b1000_0000;

  typedef enum logic [7:0] {
    IDLE   = ST_IDLE,
    CLR    = ST_CLR,
    SETTLE = ST_SETTLE,
    MSG    = ST_MSG,
    CMD    = ST_CMD,
    WAIT   = ST_WAIT,
    PAD    = ST_PAD,
    OUT    = ST_OUT
  } state_t;

  localparam logic [7:0] PAD_BYTE = 8'h80;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spongent_pad.sv
// ---------------------------------------------------------------------------
// spongent_pad
// Combinational sponge padding of one RATE-bit message word (MSB-first bytes).
// Ports:
//   word             in  RATE  raw message word
//   nbytes           in  CW    number of valid bytes in the word (0..RATE/8)
//   padded           out RATE  valid bytes kept, 0x80 at byte nbytes, zeros after
//   need_extra_block out 1     word is full, so padding needs a block of its own
// ---------------------------------------------------------------------------
module spongent_pad
  import spongent_pkg::*;
#(
  parameter int RATE = 16,
  parameter int CW   = clog2(RATE / 8 + 1)
) (
  input  logic [RATE-1:0] word,
  input  logic [CW-1:0]   nbytes,
  output logic [RATE-1:0] padded,
  output logic            need_extra_block
);

  localparam int NB = RATE / 8;

  int nb_i;

  // Byte-wise padding; byte 0 is the most significant byte of the word.
  always_comb begin
    padded = {RATE{1'b0}};
    nb_i   = 32'(nbytes);
    for (int i = 0; i < NB; i++) begin
      if (i < nb_i) begin
        padded[RATE-1-8*i -: 8] = word[RATE-1-8*i -: 8];
      end else if (i == nb_i) begin
        padded[RATE-1-8*i -: 8] = PAD_BYTE;
      end else begin
        padded[RATE-1-8*i -: 8] = 8'h00;
      end
    end
    // Counts above RATE/8 cannot be encoded as a partial word; treat as full.
    need_extra_block = (nb_i >= NB);
  end

endmodule

// File: rtl/spongent_hash_ctrl.sv
// ---------------------------------------------------------------------------
// spongent_hash_ctrl
// Host-side sequencer for a SPONGENT sponge core. Accepts a message as RATE-bit
// words, applies sponge padding, issues one absorb command per block, then
// squeezes DIGEST_BITS/RATE digest words out through a valid/ready port.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   start                       pulse that begins a hash (ignored while busy)
//   busy                        hash in progress
//   msg_valid/ready/data/last   message word stream
//   msg_last_bytes              valid bytes in the final word
//   dig_valid/ready/data/last   digest word stream
//   core_reset                  sponge core reset (reset OR internal pulse)
//   core_start_continue         one-cycle command to the core
//   core_msg_data_available     1 = absorb, 0 = squeeze
//   core_msg_data               block XORed into the core rate
//   core_busy, core_rate_data   core status and rate part of its state
// ---------------------------------------------------------------------------
module spongent_hash_ctrl
  import spongent_pkg::*;
#(
  parameter int RATE        = 16,
  parameter int DIGEST_BITS = 128
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  output logic                            busy,
  input  logic                            msg_valid,
  output logic                            msg_ready,
  input  logic [RATE-1:0]                 msg_data,
  input  logic                            msg_last,
  input  logic [clog2(RATE/8+1)-1:0]      msg_last_bytes,
  output logic                            dig_valid,
  input  logic                            dig_ready,
  output logic [RATE-1:0]                 dig_data,
  output logic                            dig_last,
  output logic                            core_reset,
  output logic                            core_start_continue,
  output logic                            core_msg_data_available,
  output logic [RATE-1:0]                 core_msg_data,
  input  logic                            core_busy,
  input  logic [RATE-1:0]                 core_rate_data
);

  localparam int CW       = clog2(RATE / 8 + 1);
  localparam int NB       = RATE / 8;
  localparam int NWORDS   = DIGEST_BITS / RATE;
  localparam int CNT_W    = (clog2(NWORDS) > 0) ? clog2(NWORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NWORDS - 1);
  localparam logic [RATE-1:0]  PAD_BLOCK = RATE'(PAD_BYTE) << (RATE - 8);

  state_t          state;
  logic            core_pulse;   // internal one-cycle core reset
  logic            final_blk;    // the last absorb has been issued
  logic            pad_pending;  // a stand-alone pad block still has to be absorbed
  logic            squeeze;      // the outstanding command is a squeeze
  logic [CNT_W-1:0] cnt;         // index of the digest word being produced

  logic [CW-1:0]   pad_count;
  logic [RATE-1:0] pad_word;
  logic            need_extra;

  // Non-final words pass through the pad unit as full words (unchanged).
  always_comb begin
    if (msg_last) begin
      pad_count = msg_last_bytes;
    end else begin
      pad_count = CW'(NB);
    end
  end

  spongent_pad #(
    .RATE (RATE),
    .CW   (CW)
  ) u_pad (
    .word             (msg_data),
    .nbytes           (pad_count),
    .padded           (pad_word),
    .need_extra_block (need_extra)
  );

  assign core_reset = reset | core_pulse;

  // Sequencer FSM; every output except core_reset is registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                   <= IDLE;
      busy                    <= 1'b0;
      msg_ready               <= 1'b0;
      dig_valid               <= 1'b0;
      dig_last                <= 1'b0;
      dig_data                <= {RATE{1'b0}};
      core_pulse              <= 1'b0;
      core_start_continue     <= 1'b0;
      core_msg_data_available <= 1'b0;
      core_msg_data           <= {RATE{1'b0}};
      final_blk               <= 1'b0;
      pad_pending             <= 1'b0;
      squeeze                 <= 1'b0;
      cnt                     <= {CNT_W{1'b0}};
    end else begin
      // Command and core reset pulse are single-cycle.
      core_pulse              <= 1'b0;
      core_start_continue     <= 1'b0;
      core_msg_data_available <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= CLR;
            busy        <= 1'b1;
            core_pulse  <= 1'b1;
            final_blk   <= 1'b0;
            pad_pending <= 1'b0;
            squeeze     <= 1'b0;
            cnt         <= {CNT_W{1'b0}};
          end
        end
        CLR: begin
          state <= SETTLE;
        end
        SETTLE: begin
          state     <= MSG;
          msg_ready <= 1'b1;
        end
        MSG: begin
          if (msg_valid) begin
            msg_ready               <= 1'b0;
            core_msg_data           <= pad_word;
            squeeze                 <= 1'b0;
            state                   <= CMD;
            core_start_continue     <= 1'b1;
            core_msg_data_available <= 1'b1;
            if (msg_last) begin
              if (need_extra) begin
                pad_pending <= 1'b1;
              end else begin
                final_blk <= 1'b1;
              end
            end
          end
        end
        CMD: begin
          // Command cycle: core_busy is not valid yet, so never sampled here.
          state <= WAIT;
        end
        WAIT: begin
          if (!core_busy) begin
            if (pad_pending) begin
              state <= PAD;
            end else if (final_blk || squeeze) begin
              dig_data  <= core_rate_data;
              dig_valid <= 1'b1;
              dig_last  <= (cnt == LAST_CNT);
              state     <= OUT;
            end else begin
              msg_ready <= 1'b1;
              state     <= MSG;
            end
          end
        end
        PAD: begin
          core_msg_data           <= PAD_BLOCK;
          pad_pending             <= 1'b0;
          final_blk               <= 1'b1;
          squeeze                 <= 1'b0;
          state                   <= CMD;
          core_start_continue     <= 1'b1;
          core_msg_data_available <= 1'b1;
        end
        OUT: begin
          if (dig_ready) begin
            dig_valid <= 1'b0;
            dig_last  <= 1'b0;
            if (cnt == LAST_CNT) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              cnt                 <= cnt + CNT_W'(1);
              squeeze             <= 1'b1;
              state               <= CMD;
              core_start_continue <= 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          msg_ready <= 1'b0;
          dig_valid <= 1'b0;
          dig_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule
